// File: rtl/tx_iq_intf_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_iq_intf_mc_if
// Description : Sample-stream bundle between the TX core / RF side and the
//               multi-channel TX I/Q interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_iq_intf_mc_if #(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int NUM_CH        = 2
);
  localparam int c_W = 2 * IQ_DATA_WIDTH * NUM_CH;

  logic [c_W-1:0] in_iq;
  logic           in_valid;
  logic           tx_hold;
  logic [c_W-1:0] out_iq;
  logic           out_valid;
  logic           out_ready;

  // System side: TX core supplies samples, RF side supplies the rate strobe
  modport master (
    output in_iq, in_valid, out_ready,
    input  tx_hold, out_iq, out_valid
  );

  modport slave (
    input  in_iq, in_valid, out_ready,
    output tx_hold, out_iq, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/tx_iq_intf_mc.sv
`default_nettype none
// ============================================================================
// Module      : tx_iq_intf_mc
// Description : Multi-channel TX I/Q interface: saturating per-channel gain,
//               FWFT sample FIFO with TX hold, arbitrary one-shot/loop replay
//               and underrun accounting.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_iq_intf_mc #(
  parameter int IQ_DATA_WIDTH   = 16,
  parameter int NUM_CH          = 2,
  parameter int FIFO_DEPTH_LOG2 = 9,
  parameter int GAIN_WIDTH      = 10,
  parameter int GAIN_SHIFT      = 7
) (
  input  wire logic                                  clk,
  input  wire logic                                  rstn,
  tx_iq_intf_mc_if.slave                             iq,
  input  wire logic [GAIN_WIDTH*NUM_CH-1:0]          bb_gain,
  input  wire logic [FIFO_DEPTH_LOG2:0]              hold_threshold,
  input  wire logic [1:0]                            mode,
  input  wire logic [2*IQ_DATA_WIDTH*NUM_CH-1:0]     arb_wr_data,
  input  wire logic                                  arb_wr_en,
  input  wire logic                                  arb_trigger,
  input  wire logic                                  tx_busy,
  output logic                                       fifo_empty,
  output logic [FIFO_DEPTH_LOG2:0]                   fifo_level,
  output logic [15:0]                                underrun_count
);

  localparam int c_W  = 2 * IQ_DATA_WIDTH * NUM_CH;
  localparam int c_CW = 2 * IQ_DATA_WIDTH;
  localparam int c_PW = IQ_DATA_WIDTH + GAIN_WIDTH;
  localparam int c_D  = 1 << FIFO_DEPTH_LOG2;

  localparam logic signed [c_PW-1:0] c_SMAX =
    {{(c_PW-IQ_DATA_WIDTH+1){1'b0}}, {(IQ_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [c_PW-1:0] c_SMIN =
    {{(c_PW-IQ_DATA_WIDTH+1){1'b1}}, {(IQ_DATA_WIDTH-1){1'b0}}};
  localparam logic [FIFO_DEPTH_LOG2:0] c_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_LOOP = 2'd2
  } state_t;

  state_t                     r_state;
  logic [c_W-1:0]             r_gain_iq;
  logic                       r_wr_req;
  logic [c_W-1:0]             r_mem [c_D];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_level;
  logic                       r_trig_d;
  logic [1:0]                 r_mode_d;
  logic [c_W-1:0]             r_out_iq;
  logic [15:0]                r_underrun;

  logic [c_W-1:0]             w_gain_iq;
  logic [c_W-1:0]             w_head;
  logic [c_W-1:0]             w_push_data;
  logic                       w_push_req;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_recirc;
  logic                       w_norm;
  logic                       w_empty;
  logic                       w_full;
  logic                       w_playing;
  logic                       w_trig_rise;
  logic                       w_mode_chg;
  logic                       w_tx_hold;

  // ---------------------------------------------------------------------------
  // Gain stage: full-precision product, arithmetic shift, clamp to sample range
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar k = 0; k < 2; k++) begin : g_comp
      logic signed [IQ_DATA_WIDTH-1:0] w_x;
      logic signed [GAIN_WIDTH-1:0]    w_g;
      logic signed [c_PW-1:0]          w_xe;
      logic signed [c_PW-1:0]          w_ge;
      logic signed [c_PW-1:0]          w_p;
      logic signed [c_PW-1:0]          w_s;

      assign w_x  = iq.in_iq[c*c_CW + k*IQ_DATA_WIDTH +: IQ_DATA_WIDTH];
      assign w_g  = bb_gain[c*GAIN_WIDTH +: GAIN_WIDTH];
      assign w_xe = {{GAIN_WIDTH{w_x[IQ_DATA_WIDTH-1]}}, w_x};
      assign w_ge = {{IQ_DATA_WIDTH{w_g[GAIN_WIDTH-1]}}, w_g};
      assign w_p  = w_xe * w_ge;
      assign w_s  = w_p >>> GAIN_SHIFT;

      assign w_gain_iq[c*c_CW + k*IQ_DATA_WIDTH +: IQ_DATA_WIDTH] =
        (w_s > c_SMAX) ? c_SMAX[IQ_DATA_WIDTH-1:0] :
        (w_s < c_SMIN) ? c_SMIN[IQ_DATA_WIDTH-1:0] :
                         w_s[IQ_DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_gain_iq <= '0;
      r_wr_req  <= 1'b0;
    end else begin
      r_gain_iq <= w_gain_iq;
      r_wr_req  <= iq.in_valid & ~w_tx_hold;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign w_norm      = (mode == 2'd0) || (mode == 2'd3);
  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == c_FULL);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_trig_rise = arb_trigger & ~r_trig_d;
  assign w_mode_chg  = (mode != r_mode_d);
  assign w_playing   = (r_state == S_PLAY) || (r_state == S_LOOP);
  assign w_pop       = iq.out_ready & ~w_empty & (w_norm | w_playing);
  assign w_recirc    = w_pop & ~w_norm & (r_state == S_LOOP);
  assign w_tx_hold   = (r_level > hold_threshold);

  always_comb begin
    w_push_req  = 1'b0;
    w_push_data = r_gain_iq;
    if (w_norm) begin
      w_push_req  = r_wr_req;
      w_push_data = r_gain_iq;
    end else if (r_state == S_IDLE) begin
      w_push_req  = arb_wr_en;
      w_push_data = arb_wr_data;
    end else if (w_recirc) begin
      w_push_req  = 1'b1;
      w_push_data = w_head;
    end
  end

  // Loop recirculation frees the head slot it refills, so it is exempt from the full drop
  assign w_push = w_push_req & (~w_full | w_recirc);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, level and replay state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_state  <= S_IDLE;
      r_trig_d <= 1'b0;
      r_mode_d <= 2'd0;
    end else begin
      r_trig_d <= arb_trigger;
      r_mode_d <= mode;
      if (w_mode_chg) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
        r_state  <= S_IDLE;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase

        case (r_state)
          S_IDLE: begin
            if (w_trig_rise && !w_empty) begin
              if (mode == 2'd1) begin
                r_state <= S_PLAY;
              end else if (mode == 2'd2) begin
                r_state <= S_LOOP;
              end
            end
          end
          S_PLAY: begin
            if (w_empty) begin
              r_state <= S_IDLE;
            end
          end
          S_LOOP: begin
            if (w_trig_rise) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output sample and underrun counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_iq   <= '0;
      r_underrun <= '0;
    end else begin
      if (iq.out_ready) begin
        r_out_iq <= w_pop ? w_head : '0;
      end
      if (w_norm && iq.out_ready && w_empty && tx_busy && (r_underrun != 16'hFFFF)) begin
        r_underrun <= r_underrun + 16'd1;
      end
    end
  end

  assign iq.out_iq      = r_out_iq;
  assign iq.out_valid   = 1'b1;
  assign iq.tx_hold     = w_tx_hold;
  assign fifo_empty     = w_empty;
  assign fifo_level     = r_level;
  assign underrun_count = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_tx_iq_intf_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_iq_intf_mc
// Description : Directed self-checking bench for tx_iq_intf_mc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_iq_intf_mc;

  localparam int IQW = 16;
  localparam int NCH = 2;
  localparam int DL2 = 9;
  localparam int GW  = 10;
  localparam int GS  = 7;
  localparam int W   = 2 * IQW * NCH;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [GW*NCH-1:0] bb_gain;
  logic [DL2:0]      hold_threshold;
  logic [1:0]        mode;
  logic [W-1:0]      arb_wr_data;
  logic              arb_wr_en;
  logic              arb_trigger;
  logic              tx_busy;
  logic              fifo_empty;
  logic [DL2:0]      fifo_level;
  logic [15:0]       underrun_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tx_iq_intf_mc_if #(.IQ_DATA_WIDTH(IQW), .NUM_CH(NCH)) iq ();

  tx_iq_intf_mc #(
    .IQ_DATA_WIDTH  (IQW),
    .NUM_CH         (NCH),
    .FIFO_DEPTH_LOG2(DL2),
    .GAIN_WIDTH     (GW),
    .GAIN_SHIFT     (GS)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .iq            (iq),
    .bb_gain       (bb_gain),
    .hold_threshold(hold_threshold),
    .mode          (mode),
    .arb_wr_data   (arb_wr_data),
    .arb_wr_en     (arb_wr_en),
    .arb_trigger   (arb_trigger),
    .tx_busy       (tx_busy),
    .fifo_empty    (fifo_empty),
    .fifo_level    (fifo_level),
    .underrun_count(underrun_count)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] in_a, exp_a, in_s, exp_pos, exp_neg, exp_u;
    logic [W-1:0] words [8];
    logic [W-1:0] lp [4];
    int rise_lvl, max_lvl, s;

    in_a    = {16'hFFCE, 16'h0064, 16'hFFCE, 16'h0064};   // Q=-50, I=100 on both channels
    exp_a   = {16'hFFE7, 16'h0032, 16'hFFCE, 16'h0064};   // ch1 at half gain
    in_s    = {16'h0000, 16'h0100, 16'h8000, 16'h7FFF};
    exp_pos = {16'h0000, 16'h03FE, 16'h8000, 16'h7FFF};   // gain 511
    exp_neg = {16'h0000, 16'hFC00, 16'h7FFF, 16'h8000};   // gain -512
    exp_u   = in_a;                                        // unity gain
    for (int i = 0; i < 8; i++) words[i] = 64'hA0B0_C0D0_0000_0001 + 64'(i);
    lp[0] = 64'h0A0A_0A0A_0A0A_0A0A;
    lp[1] = 64'h0B0B_0B0B_0B0B_0B0B;
    lp[2] = 64'h0C0C_0C0C_0C0C_0C0C;
    lp[3] = 64'h0D0D_0D0D_0D0D_0D0D;

    iq.in_iq       = '0;
    iq.in_valid    = 1'b0;
    iq.out_ready   = 1'b0;
    bb_gain        = {10'd128, 10'd128};
    hold_threshold = 10'd500;
    mode           = 2'd0;
    arb_wr_data    = '0;
    arb_wr_en      = 1'b0;
    arb_trigger    = 1'b0;
    tx_busy        = 1'b0;

    // Reset state
    rstn = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 64'(iq.out_valid), 64'd1);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_empty", 64'(fifo_empty), 64'd1);
    chk("rst_tx_hold", 64'(iq.tx_hold), 64'd0);
    chk("rst_out_iq", iq.out_iq, 64'd0);
    chk("rst_underrun", 64'(underrun_count), 64'd0);
    rstn = 1'b1;
    tick();

    // Normal path: 10 samples, 3-cycle latency
    bb_gain      = {10'd64, 10'd128};
    iq.in_iq     = in_a;
    iq.out_ready = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      iq.in_valid = (k <= 10);
      tick();
      if (k == 1) chk("norm_empty_n1", 64'(fifo_empty), 64'd1);
      if (k == 2) chk("norm_empty_n2", 64'(fifo_empty), 64'd0);
      chk($sformatf("norm_out_%0d", k), iq.out_iq, (k >= 3 && k <= 12) ? exp_a : 64'd0);
    end
    iq.in_valid = 1'b0;
    chk("norm_level_end", 64'(fifo_level), 64'd0);

    // Saturation, positive and negative gain
    bb_gain     = {10'd511, 10'd511};
    iq.in_iq    = in_s;
    iq.in_valid = 1'b1;
    tick();
    iq.in_valid = 1'b0;
    tick();
    tick();
    chk("sat_pos", iq.out_iq, exp_pos);
    tick();
    bb_gain     = {10'h200, 10'h200};
    iq.in_valid = 1'b1;
    tick();
    iq.in_valid = 1'b0;
    tick();
    tick();
    chk("sat_neg", iq.out_iq, exp_neg);
    tick();

    // TX hold threshold
    iq.out_ready   = 1'b0;
    hold_threshold = 10'd20;
    iq.in_valid    = 1'b1;
    rise_lvl = -1;
    max_lvl  = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (iq.tx_hold && rise_lvl < 0) rise_lvl = int'(fifo_level);
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    end
    chk("hold_rise_level", 64'(rise_lvl), 64'd21);
    chk("hold_max_level", 64'(max_lvl), 64'd22);
    chk("hold_final_level", 64'(fifo_level), 64'd22);
    chk("hold_asserted", 64'(iq.tx_hold), 64'd1);
    iq.in_valid    = 1'b0;
    hold_threshold = 10'd500;
    iq.out_ready   = 1'b1;
    repeat (30) tick();
    chk("hold_drained", 64'(fifo_level), 64'd0);
    iq.out_ready = 1'b0;

    // Arbitrary one-shot
    mode = 2'd1;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      arb_wr_data = words[i];
      arb_wr_en   = 1'b1;
      tick();
      if (i == 0) chk("os_first_visible", 64'(fifo_empty), 64'd0);
    end
    arb_wr_en = 1'b0;
    chk("os_level_loaded", 64'(fifo_level), 64'd8);
    arb_trigger = 1'b1;
    tick();
    s = 0;
    for (int i = 0; i < 48; i++) begin
      iq.out_ready = (i % 4 == 0);
      tick();
      if (iq.out_ready) begin
        chk($sformatf("os_out_%0d", s), iq.out_iq, (s < 8) ? words[s] : 64'd0);
        s++;
      end
    end
    iq.out_ready = 1'b0;
    chk("os_level_end", 64'(fifo_level), 64'd0);
    chk("os_empty_end", 64'(fifo_empty), 64'd1);
    arb_wr_data = words[0];
    arb_wr_en   = 1'b1;
    tick();
    arb_wr_en = 1'b0;
    chk("os_idle_accepts_write", 64'(fifo_level), 64'd1);

    // Arbitrary loop
    arb_trigger = 1'b0;
    mode = 2'd2;
    tick();
    tick();
    chk("loop_flushed", 64'(fifo_level), 64'd0);
    for (int i = 0; i < 4; i++) begin
      arb_wr_data = lp[i];
      arb_wr_en   = 1'b1;
      tick();
    end
    arb_wr_en   = 1'b0;
    arb_trigger = 1'b1;
    tick();
    iq.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("loop_out_%0d", i), iq.out_iq, lp[i % 4]);
      chk($sformatf("loop_level_%0d", i), 64'(fifo_level), 64'd4);
    end
    iq.out_ready = 1'b0;
    arb_trigger  = 1'b0;
    tick();
    arb_trigger = 1'b1;
    tick();
    iq.out_ready = 1'b1;
    tick();
    chk("loop_stop_out", iq.out_iq, 64'd0);
    chk("loop_stop_level", 64'(fifo_level), 64'd4);
    iq.out_ready = 1'b0;
    arb_trigger  = 1'b0;

    // Underrun counting
    mode = 2'd0;
    tick();
    tick();
    chk("ur_flushed", 64'(fifo_level), 64'd0);
    tx_busy      = 1'b1;
    iq.out_ready = 1'b1;
    repeat (5) tick();
    chk("ur_count5", 64'(underrun_count), 64'd5);
    tx_busy = 1'b0;
    tick();
    chk("ur_hold_not_busy", 64'(underrun_count), 64'd5);
    iq.out_ready = 1'b0;

    // Mode change flush with 30 queued words
    bb_gain     = {10'd128, 10'd128};
    iq.in_iq    = in_a;
    iq.in_valid = 1'b1;
    repeat (30) tick();
    iq.in_valid = 1'b0;
    tick();
    tick();
    chk("mc_level_queued", 64'(fifo_level), 64'd30);
    mode = 2'd1;
    tick();
    tick();
    chk("mc_level_flushed", 64'(fifo_level), 64'd0);
    chk("mc_empty", 64'(fifo_empty), 64'd1);

    // Reset mid-operation
    mode = 2'd0;
    tick();
    tick();
    iq.in_valid = 1'b1;
    repeat (3) tick();
    iq.in_valid = 1'b0;
    tick();
    tick();
    chk("mr_level_before", 64'(fifo_level), 64'd3);
    iq.out_ready = 1'b1;
    tick();
    iq.out_ready = 1'b0;
    chk("mr_out_before", iq.out_iq, exp_u);
    rstn = 1'b0;
    tick();
    chk("mr_level", 64'(fifo_level), 64'd0);
    chk("mr_empty", 64'(fifo_empty), 64'd1);
    chk("mr_out_iq", iq.out_iq, 64'd0);
    chk("mr_underrun", 64'(underrun_count), 64'd0);
    chk("mr_out_valid", 64'(iq.out_valid), 64'd1);
    rstn = 1'b1;
    tick();
    chk("mr_empty_after", 64'(fifo_empty), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
